// File: rtl/decoder_pkg.sv
// Shared types and constants for the scan/parallel decoder.
// Holds the output-stage state encoding and the mode select values.
package decoder_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_core.sv
// Combinational binary-to-one-hot decoder.
// Exactly one output bit is high for every input code.
module decoder_core #(
  parameter int IN_W = 6
) (
  input  logic [IN_W-1:0]      code,
  output logic [2**IN_W-1:0]   onehot
);

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan_par.sv
// One-hot decoder with a one-entry registered output stage, fed either
// by an external code (DIRECT) or by an internal scan counter (SCAN).
//
// state | meaning
// EMPTY | no result held, out_valid=0
// FULL  | result held in out/idx, out_valid=1
module decoder_scan_par
  import decoder_pkg::*;
#(
  parameter  int IN_W  = 6,
  localparam int OUT_W = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [IN_W-1:0]  in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             step,
  input  logic             clr,
  output logic [OUT_W-1:0] out,
  output logic [IN_W-1:0]  idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wrap
);

  state_t            state, state_nxt;
  logic [IN_W-1:0]   cnt;
  logic [IN_W-1:0]   cnt_eff;
  logic [IN_W-1:0]   code_sel;
  logic [OUT_W-1:0]  dec;
  logic              load_direct;
  logic              load_scan;
  logic              load;

  assign out_valid   = (state == FULL);
  assign in_ready    = !out_valid || out_ready;

  assign load_direct = (mode == MODE_DIRECT) && in_valid && in_ready;
  assign load_scan   = (mode == MODE_SCAN) && step && in_ready;
  assign load        = load_direct || load_scan;

  // clr wins over the stored count, so a clr+step scan emits code 0
  assign cnt_eff  = clr ? '0 : cnt;
  assign code_sel = load_scan ? cnt_eff : in;

  decoder_core #(.IN_W(IN_W)) u_core (
    .code   (code_sel),
    .onehot (dec)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (load) state_nxt = FULL;
      FULL:  if (out_ready && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= '0;
      idx  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= load_scan && (&cnt_eff);
      if (load) begin
        out <= dec;
        idx <= code_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load_scan) begin
      cnt <= cnt_eff + IN_W'(1);
    end else if (clr) begin
      cnt <= '0;
    end
  end

endmodule

// File: tb/tb_decoder_scan_par.sv
// Directed self-checking bench for decoder_scan_par (IN_W=6).
// Loops cover long DIRECT/SCAN runs; a vector table covers mixed-mode sequences.
module tb_decoder_scan_par;

  localparam int IN_W  = 6;
  localparam int OUT_W = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mode;
  logic [IN_W-1:0]  code_in;
  logic             in_valid;
  logic             in_ready;
  logic             step;
  logic             clr;
  logic [OUT_W-1:0] out;
  logic [IN_W-1:0]  idx;
  logic             out_valid;
  logic             out_ready;
  logic             wrap;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic            mode;
    logic [IN_W-1:0] in;
    logic            in_valid;
    logic            step;
    logic            clr;
    logic            out_ready;
    logic            exp_valid;
    logic [IN_W-1:0] exp_idx;
    logic            exp_wrap;
  } vec_t;

  vec_t tbl[13];

  decoder_scan_par #(.IN_W(IN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in        (code_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .step      (step),
    .clr       (clr),
    .out       (out),
    .idx       (idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input int c, input logic v, input logic s,
                       input logic cl, input logic r);
    mode      = m;
    code_in   = IN_W'(c);
    in_valid  = v;
    step      = s;
    clr       = cl;
    out_ready = r;
  endtask

  function automatic vec_t mk(int m, int i, int v, int s, int c, int r,
                              int ev, int ei, int ew);
    vec_t t;
    t.mode = 1'(m); t.in = IN_W'(i); t.in_valid = 1'(v); t.step = 1'(s);
    t.clr = 1'(c); t.out_ready = 1'(r); t.exp_valid = 1'(ev);
    t.exp_idx = IN_W'(ei); t.exp_wrap = 1'(ew);
    return t;
  endfunction

  initial begin
    int wraps;
    logic [63:0] one;

    // starts with cnt=20 and out_ready=1
    tbl[0]  = mk(1, 0, 0, 1, 0, 1, 1, 20, 0);
    tbl[1]  = mk(0, 5, 1, 0, 0, 1, 1,  5, 0);
    tbl[2]  = mk(1, 0, 0, 1, 0, 1, 1, 21, 0);
    tbl[3]  = mk(0, 63, 1, 0, 0, 1, 1, 63, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 1, 0,  0, 0);
    tbl[5]  = mk(0, 9, 0, 0, 0, 1, 0,  0, 0);
    tbl[6]  = mk(0, 7, 1, 0, 0, 0, 1,  7, 0);
    tbl[7]  = mk(0, 8, 1, 0, 0, 0, 1,  7, 0);
    tbl[8]  = mk(0, 8, 1, 0, 0, 1, 1,  8, 0);
    tbl[9]  = mk(1, 0, 0, 0, 1, 1, 0,  0, 0);
    tbl[10] = mk(1, 0, 0, 1, 0, 1, 1,  0, 0);
    tbl[11] = mk(0, 0, 0, 0, 1, 1, 0,  0, 0);
    tbl[12] = mk(1, 0, 0, 1, 0, 1, 1,  0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_idx", 64'(idx), 64'd0);
    chk("rst_wrap", 64'(wrap), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // DIRECT sweep, one code per clock
    for (int i = 0; i < OUT_W; i++) begin
      drive(0, i, 1, 0, 0, 1);
      tick();
      one = 64'd1 << i;
      chk("direct_out", 64'(out), one);
      chk("direct_idx", 64'(idx), 64'(i));
      chk("direct_valid", 64'(out_valid), 64'd1);
      chk("direct_wrap", 64'(wrap), 64'd0);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("direct_drain", 64'(out_valid), 64'd0);

    // SCAN run of 130 codes
    wraps = 0;
    for (int k = 0; k < 130; k++) begin
      drive(1, 0, 0, 1, 0, 1);
      tick();
      if (wrap) wraps++;
      chk("scan_idx", 64'(idx), 64'(k % OUT_W));
      chk("scan_out", 64'(out), 64'd1 << (k % OUT_W));
      chk("scan_wrap", 64'(wrap), 64'((k % OUT_W) == OUT_W - 1));
    end
    chk("scan_wrap_count", 64'(wraps), 64'd2);
    drive(1, 0, 0, 0, 0, 1);
    tick();
    chk("scan_drain", 64'(out_valid), 64'd0);

    // backpressure with cnt=2; step/in/mode change must be ignored while held
    drive(0, 10, 1, 0, 0, 0);
    tick();
    chk("bp_load_idx", 64'(idx), 64'd10);
    for (int h = 0; h < 5; h++) begin
      drive(1, 20, 1, 1, 0, 0);
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("bp_out", 64'(out), 64'd1 << 10);
      chk("bp_idx", 64'(idx), 64'd10);
      chk("bp_valid", 64'(out_valid), 64'd1);
    end
    drive(1, 20, 1, 1, 0, 1);
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp_next_idx", 64'(idx), 64'd2);
    chk("bp_next_valid", 64'(out_valid), 64'd1);

    // clr together with step at cnt=40
    drive(1, 0, 0, 0, 1, 1);
    tick();
    for (int k = 0; k < 40; k++) begin
      drive(1, 0, 0, 1, 0, 1);
      tick();
    end
    chk("clr_pre_idx", 64'(idx), 64'd39);
    drive(1, 0, 0, 1, 1, 1);
    tick();
    chk("clr_step_idx", 64'(idx), 64'd0);
    chk("clr_step_out", 64'(out), 64'd1);
    drive(1, 0, 0, 1, 0, 1);
    tick();
    chk("clr_follow_idx", 64'(idx), 64'd1);
    chk("clr_follow_wrap", 64'(wrap), 64'd0);

    // bring cnt to 20 for the mixed-mode table
    drive(1, 0, 0, 0, 1, 1);
    tick();
    for (int k = 0; k < 20; k++) begin
      drive(1, 0, 0, 1, 0, 1);
      tick();
    end

    for (int v = 0; v < 13; v++) begin
      drive(tbl[v].mode, int'(tbl[v].in), tbl[v].in_valid, tbl[v].step,
            tbl[v].clr, tbl[v].out_ready);
      tick();
      chk($sformatf("tbl%0d_valid", v), 64'(out_valid), 64'(tbl[v].exp_valid));
      chk($sformatf("tbl%0d_wrap", v), 64'(wrap), 64'(tbl[v].exp_wrap));
      if (tbl[v].exp_valid) begin
        chk($sformatf("tbl%0d_idx", v), 64'(idx), 64'(tbl[v].exp_idx));
        chk($sformatf("tbl%0d_out", v), 64'(out), 64'd1 << tbl[v].exp_idx);
      end
    end

    // reset while a scan result idx=33 is held
    drive(1, 0, 0, 0, 1, 1);
    tick();
    for (int k = 0; k < 34; k++) begin
      drive(1, 0, 0, 1, 0, 1);
      tick();
    end
    chk("mid_idx", 64'(idx), 64'd33);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 64'(out), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_idx", 64'(idx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 1, 0, 1);
    tick();
    chk("post_rst_idx", 64'(idx), 64'd0);
    chk("post_rst_out", 64'(out), 64'd1);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    drive(1, 0, 0, 1, 0, 1);
    tick();
    chk("post_rst_idx2", 64'(idx), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_scan_par.md
DECODER_SCAN_PAR -- requirements
Module: decoder_scan_par

Interface
REQ-001 SHALL have parameter IN_W, default 6: code width, legal range 2..8.
REQ-002 SHALL derive OUT_W = 2**IN_W as a localparam, default 64: one-hot output width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port mode, input, 1 bit: 0 = DIRECT (decode in), 1 = SCAN (decode internal counter).
REQ-006 SHALL have port in, input, IN_W bits: code to decode in DIRECT mode.
REQ-007 SHALL have port in_valid, input, 1 bit: in is valid (DIRECT mode only).
REQ-008 SHALL have port in_ready, output, 1 bit: output stage can accept a new code.
REQ-009 SHALL have port step, input, 1 bit: request one scan advance (SCAN mode only).
REQ-010 SHALL have port clr, input, 1 bit: synchronous clear of the scan counter.
REQ-011 SHALL have port out, output, OUT_W bits: registered one-hot result; bit k high means code k.
REQ-012 SHALL have port idx, output, IN_W bits: binary code of the current out.
REQ-013 SHALL have port out_valid, output, 1 bit: out and idx are valid.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts out.
REQ-015 SHALL have port wrap, output, 1 bit: one-cycle pulse when the scan counter wraps from OUT_W-1 to 0.

Function
REQ-016 SHALL drive in_ready combinationally as !out_valid || out_ready (one-entry output stage).
REQ-017 SHALL implement a two-state FSM, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 SHALL move EMPTY->FULL on a load, FULL->EMPTY on out_ready with no load, and stay FULL on out_ready with a load.
REQ-019 SHALL define a DIRECT load as mode=0 && in_valid && in_ready; at the next edge out = 1<<in, idx = in.
REQ-020 SHALL define a SCAN load as mode=1 && step && in_ready; at the next edge out = 1<<cnt, idx = cnt, and cnt advances by 1 mod OUT_W.
REQ-021 SHALL have 1-cycle latency from load to out_valid and 0-cycle bubble under continuous out_ready, giving one code per clock.
REQ-022 SHALL keep out, idx and out_valid stable while out_valid=1 && out_ready=0; in and step SHALL be ignored in that state.
REQ-023 SHALL pulse wrap high in the cycle following a SCAN load with cnt=OUT_W-1, and SHALL NOT pulse it for a DIRECT load with in=OUT_W-1.
REQ-024 SHALL set cnt to 0 on clr regardless of mode; clr with a SCAN load SHALL output code 0 and leave cnt=1 (clr has priority).
REQ-025 SHALL leave cnt unchanged by a mode change, and SHALL NOT alter or drop a held FULL output on a mode change.
REQ-026 SHALL keep out exactly one-hot whenever out_valid=1 and all-zero after reset until the first load.

Reset
REQ-027 SHALL, on rst_n low and independent of clk, set out=0, idx=0, out_valid=0, wrap=0, cnt=0 and the FSM to EMPTY.
REQ-028 SHALL discard any held output on reset mid-transfer, and SHALL accept a load on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place the FSM state type (EMPTY/FULL) and the mode constants (MODE_DIRECT=0, MODE_SCAN=1) in shared package decoder_pkg.
REQ-030 SHALL instantiate a combinational sub-module decoder_core (IN_W code in, 2**IN_W one-hot out) for the decode.
REQ-031 SHALL register the decoded output in decoder_scan_par.

Verification
REQ-032 SHALL check DIRECT, IN_W=6, out_ready=1, in=0..63 over consecutive cycles -> out=1<<in one cycle later, in_valid=1 every cycle, no wrap pulse.
REQ-033 SHALL check SCAN, step=1 held for 130 cycles with out_ready=1 -> idx sequence 0..63,0..63,0,1; wrap high exactly twice, in the cycles after idx=63.
REQ-034 SHALL check backpressure: out_ready=0 for 5 cycles with out=1<<10 -> out and idx hold, in_ready=0, cnt unchanged; the next code appears 1 cycle after out_ready=1.
REQ-035 SHALL check clr together with step while cnt=40 -> next idx=0 and the following idx=1.
REQ-036 SHALL check rst_n low mid-scan at idx=33 -> out=0 and out_valid=0 immediately; the first scan after release gives idx=0.
REQ-037 SHALL check a mode switch SCAN->DIRECT->SCAN with cnt=20 and in=5 -> outputs 20, 5, 21 in order.
